// File: rtl/tl_ped_sched.sv
// Pedestrian-crossing scheduler: latches button requests, round-robins one road per all-red window.
// Define TL_PED_FLASH_EN to include the flashing DON'T WALK phase between WALK and CLEAR.
module tl_ped_sched #(
    parameter logic [15:0] WALK_TICKS  = 16'd20,
    parameter logic [15:0] FLASH_TICKS = 16'd10,
    parameter logic [15:0] CLEAR_TICKS = 16'd4,
    parameter logic [15:0] FLASH_HALF  = 16'd2
) (
    input  logic       clk,
    input  logic       arstN,
    input  logic [3:0] ped_btn,
    input  logic       tl_red,
    output logic       hold_req,
    output logic [3:0] ped_walk,
    output logic [3:0] ped_dontwalk,
    output logic [3:0] pending,
    output logic [1:0] grant_idx,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WALK,
        S_CLEAR
`ifdef TL_PED_FLASH_EN
        , S_FLASH
`endif
    } state_t;

    function automatic logic [15:0] load_val(input logic [15:0] t);
        return (t == 16'd0) ? 16'd0 : t - 16'd1;
    endfunction

    localparam logic [15:0] WALK_LD  = load_val(WALK_TICKS);
    localparam logic [15:0] CLEAR_LD = load_val(CLEAR_TICKS);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [3:0]  btn_q;
    logic [3:0]  rise;
    logic [3:0]  pending_d;
    logic [3:0]  latch_mask;
    logic [1:0]  rr_ptr, rr_d;
    logic [1:0]  grant_d;
    logic [1:0]  arb_idx;
    logic [1:0]  cand;
    logic        found;
    logic        do_grant;
    logic        busy;
    logic        fault_d;
    logic [3:0]  onehot_d;
    logic [3:0]  walk_d;
    logic [3:0]  dw_d;

`ifdef TL_PED_FLASH_EN
    localparam logic [15:0] FLASH_LD = load_val(FLASH_TICKS);
    localparam logic [15:0] HALF_LD  = load_val(FLASH_HALF);

    logic        blink, blink_d;
    logic [15:0] bcnt, bcnt_d;
`else
    logic [31:0] unused_flash;
    assign unused_flash = {FLASH_TICKS, FLASH_HALF};
`endif

    always_comb begin
        rise     = ped_btn & ~btn_q;
        state_d  = state;
        cnt_d    = cnt;
        grant_d  = grant_idx;
        rr_d     = rr_ptr;
        fault_d  = fault;
        do_grant = 1'b0;
        found    = 1'b0;
        arb_idx  = rr_ptr;
        cand     = 2'd0;
`ifdef TL_PED_FLASH_EN
        blink_d  = blink;
        bcnt_d   = bcnt;
`endif

        // Search starts just past the last served road
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && pending[cand]) begin
                found   = 1'b1;
                arb_idx = cand;
            end
        end

        unique case (state)
            S_IDLE: begin
                if (pending != 4'd0)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (tl_red && found) begin
                    state_d  = S_WALK;
                    cnt_d    = WALK_LD;
                    grant_d  = arb_idx;
                    rr_d     = arb_idx;
                    do_grant = 1'b1;
                end
            end
            S_WALK: begin
                if (!tl_red) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LD;
                    fault_d = 1'b1;
                end else if (cnt == 16'd0) begin
`ifdef TL_PED_FLASH_EN
                    state_d = S_FLASH;
                    cnt_d   = FLASH_LD;
                    blink_d = 1'b0;
                    bcnt_d  = HALF_LD;
`else
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LD;
`endif
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
`ifdef TL_PED_FLASH_EN
            S_FLASH: begin
                if (!tl_red) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LD;
                    fault_d = 1'b1;
                end else if (cnt == 16'd0) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LD;
                end else begin
                    cnt_d = cnt - 16'd1;
                    if (bcnt == 16'd0) begin
                        blink_d = ~blink;
                        bcnt_d  = HALF_LD;
                    end else begin
                        bcnt_d = bcnt - 16'd1;
                    end
                end
            end
`endif
            S_CLEAR: begin
                if (cnt == 16'd0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // The road being served cannot re-request until CLEAR
        busy = (state == S_WALK);
`ifdef TL_PED_FLASH_EN
        busy = busy | (state == S_FLASH);
`endif
        latch_mask = busy ? ~(4'b0001 << grant_idx) : 4'b1111;
        pending_d  = pending | (rise & latch_mask);
        if (do_grant)
            pending_d = pending_d & ~(4'b0001 << arb_idx);

        onehot_d = 4'b0001 << grant_d;
        walk_d   = (state_d == S_WALK) ? onehot_d : 4'b0000;
        dw_d     = (state_d == S_WALK) ? ~onehot_d : 4'b1111;
`ifdef TL_PED_FLASH_EN
        if (state_d == S_FLASH)
            dw_d = blink_d ? 4'b1111 : ~onehot_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!arstN) begin
            state        <= S_IDLE;
            cnt          <= 16'd0;
            btn_q        <= 4'd0;
            pending      <= 4'd0;
            rr_ptr       <= 2'd3;
            grant_idx    <= 2'd0;
            fault        <= 1'b0;
            hold_req     <= 1'b0;
            ped_walk     <= 4'b0000;
            ped_dontwalk <= 4'b1111;
`ifdef TL_PED_FLASH_EN
            blink        <= 1'b0;
            bcnt         <= 16'd0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            btn_q        <= ped_btn;
            pending      <= pending_d;
            rr_ptr       <= rr_d;
            grant_idx    <= grant_d;
            fault        <= fault_d;
            hold_req     <= (state_d != S_IDLE);
            ped_walk     <= walk_d;
            ped_dontwalk <= dw_d;
`ifdef TL_PED_FLASH_EN
            blink        <= blink_d;
            bcnt         <= bcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tl_ped_sched.sv
// Directed bench for tl_ped_sched: vector table plus hand sequences for
// lamp timing, collisions, loss of red and mid-phase reset.
module tb_tl_ped_sched;

    localparam int W = 20;
    localparam int F = 10;
    localparam int C = 4;
    localparam int H = 2;
`ifdef TL_PED_FLASH_EN
    localparam int FW = F;
`else
    localparam int FW = 0;
`endif
    localparam int WIN = W + FW + C;

    logic       clk;
    logic       arstN;
    logic [3:0] ped_btn;
    logic       tl_red;
    logic       hold_req;
    logic [3:0] ped_walk;
    logic [3:0] ped_dontwalk;
    logic [3:0] pending;
    logic [1:0] grant_idx;
    logic       fault;

    int total = 0;
    int bad   = 0;
    int pos;
    int n;

    tl_ped_sched dut (
        .clk          (clk),
        .arstN        (arstN),
        .ped_btn      (ped_btn),
        .tl_red       (tl_red),
        .hold_req     (hold_req),
        .ped_walk     (ped_walk),
        .ped_dontwalk (ped_dontwalk),
        .pending      (pending),
        .grant_idx    (grant_idx),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic [3:0] btn;
        logic       red;
        int         ncyc;
        logic       hold;
        logic [3:0] walk;
        logic [3:0] dw;
        logic [3:0] pend;
        logic [1:0] grant;
        logic       flt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rs, input logic [3:0] b, input logic r,
                       input int nc, input logic h, input logic [3:0] wk,
                       input logic [3:0] d, input logic [3:0] p,
                       input logic [1:0] g, input logic fl);
        vec_t v;
        v.rstn = rs; v.btn = b; v.red = r; v.ncyc = nc;
        v.hold = h; v.walk = wk; v.dw = d; v.pend = p;
        v.grant = g; v.flt = fl;
        tv.push_back(v);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic h, input logic [3:0] wk,
                           input logic [3:0] d, input logic [3:0] p,
                           input logic [1:0] g, input logic fl);
        chk({nm, ".hold"},  int'(hold_req),     int'(h));
        chk({nm, ".walk"},  int'(ped_walk),     int'(wk));
        chk({nm, ".dw"},    int'(ped_dontwalk), int'(d));
        chk({nm, ".pend"},  int'(pending),      int'(p));
        chk({nm, ".grant"}, int'(grant_idx),    int'(g));
        chk({nm, ".fault"}, int'(fault),        int'(fl));
    endtask

    initial begin
        arstN   = 1'b0;
        ped_btn = 4'd0;
        tl_red  = 1'b0;

        // reset, round-robin 0,1,3, then handshake wait on road 1
        add(0, 4'h0,    0, 2,   0, 4'h0,    4'hf,    4'h0,    2'd0, 0);
        add(1, 4'b1011, 1, 1,   0, 4'h0,    4'hf,    4'b1011, 2'd0, 0);
        add(1, 4'h0,    1, 1,   1, 4'h0,    4'hf,    4'b1011, 2'd0, 0);
        add(1, 4'h0,    1, 1,   1, 4'b0001, 4'b1110, 4'b1010, 2'd0, 0);
        add(1, 4'h0,    1, WIN, 0, 4'h0,    4'hf,    4'b1010, 2'd0, 0);
        add(1, 4'h0,    1, 1,   1, 4'h0,    4'hf,    4'b1010, 2'd0, 0);
        add(1, 4'h0,    1, 1,   1, 4'b0010, 4'b1101, 4'b1000, 2'd1, 0);
        add(1, 4'h0,    1, WIN, 0, 4'h0,    4'hf,    4'b1000, 2'd1, 0);
        add(1, 4'h0,    1, 1,   1, 4'h0,    4'hf,    4'b1000, 2'd1, 0);
        add(1, 4'h0,    1, 1,   1, 4'b1000, 4'b0111, 4'b0000, 2'd3, 0);
        add(1, 4'h0,    1, WIN, 0, 4'h0,    4'hf,    4'h0,    2'd3, 0);
        add(1, 4'h0,    1, 5,   0, 4'h0,    4'hf,    4'h0,    2'd3, 0);
        add(1, 4'b0010, 0, 1,   0, 4'h0,    4'hf,    4'b0010, 2'd3, 0);
        add(1, 4'h0,    0, 1,   1, 4'h0,    4'hf,    4'b0010, 2'd3, 0);
        add(1, 4'h0,    0, 25,  1, 4'h0,    4'hf,    4'b0010, 2'd3, 0);
        add(1, 4'h0,    0, 25,  1, 4'h0,    4'hf,    4'b0010, 2'd3, 0);
        add(1, 4'h0,    1, 1,   1, 4'b0010, 4'b1101, 4'h0,    2'd1, 0);
        add(1, 4'h0,    1, WIN, 0, 4'h0,    4'hf,    4'h0,    2'd1, 0);

        for (int i = 0; i < tv.size(); i++) begin
            arstN   = tv[i].rstn;
            ped_btn = tv[i].btn;
            tl_red  = tv[i].red;
            tick(tv[i].ncyc);
            chk_all($sformatf("vec%0d", i), tv[i].hold, tv[i].walk,
                    tv[i].dw, tv[i].pend, tv[i].grant, tv[i].flt);
        end

        // single request on road 2: lamp timing through the window
        ped_btn = 4'b0100;
        tick(1);
        chk("press_pend", int'(pending), 4);
        chk("press_hold0", int'(hold_req), 0);
        ped_btn = 4'd0;
        tick(1);
        chk("press_hold1", int'(hold_req), 1);
        chk("hold_walk0", int'(ped_walk), 0);
        tick(1);
        chk("grant2_walk", int'(ped_walk), int'(4'b0100));
        chk("grant2_dw", int'(ped_dontwalk), int'(4'b1011));
        chk("grant2_idx", int'(grant_idx), 2);
        chk("grant2_pend", int'(pending), 0);
        n = 0;
        while (ped_walk == 4'b0100 && n < 200) begin
            n++;
            tick(1);
        end
        chk("walk_len", n, W);
`ifdef TL_PED_FLASH_EN
        for (int i = 0; i < F; i++) begin
            chk($sformatf("blink%0d", i), int'(ped_dontwalk),
                (((i / H) % 2) == 1) ? 15 : int'(4'b1011));
            chk($sformatf("flash_walk%0d", i), int'(ped_walk), 0);
            tick(1);
        end
`endif
        for (int i = 0; i < C; i++) begin
            chk($sformatf("clear_dw%0d", i), int'(ped_dontwalk), 15);
            chk($sformatf("clear_hold%0d", i), int'(hold_req), 1);
            tick(1);
        end
        chk("idle_after", int'(hold_req), 0);

        // collisions: road 0 served, re-press ignored, other road latched
        ped_btn = 4'b0001;
        tick(1);
        ped_btn = 4'd0;
        tick(2);
        chk("col_grant", int'(grant_idx), 0);
        chk("col_walk", int'(ped_walk), 1);
        pos = 1;
        tick(4);
        ped_btn = 4'b0001;
        tick(1);
        ped_btn = 4'd0;
        tick(1);
        pos = 7;
        chk("repress_walk", int'(pending), 0);
`ifdef TL_PED_FLASH_EN
        tick(W + 1 - pos);
        pos = W + 1;
`endif
        ped_btn = 4'b0100;
        tick(1);
        ped_btn = 4'd0;
        pos = pos + 1;
        chk("other_latch", int'(pending), 4);
        tick(W + FW + 1 - pos);
        ped_btn = 4'b0001;
        tick(1);
        ped_btn = 4'd0;
        pos = W + FW + 2;
        chk("clear_latch", int'(pending), 5);
        tick(WIN + 1 - pos);
        chk("gap_idle", int'(hold_req), 0);
        tick(1);
        chk("gap_hold", int'(hold_req), 1);
        tick(1);
        chk("rr_after_clear", int'(grant_idx), 2);
        chk("rr_pend", int'(pending), 1);
        tick(WIN);
        chk("gap2_idle", int'(hold_req), 0);
        tick(1);
        ped_btn = 4'b0001;
        tick(1);
        ped_btn = 4'd0;
        chk("gedge_grant", int'(grant_idx), 0);
        chk("gedge_pend", int'(pending), 0);
        chk("gedge_walk", int'(ped_walk), 1);

        // loss of red mid-WALK
        tick(3);
        tl_red = 1'b0;
        tick(1);
        chk("fault_set", int'(fault), 1);
        chk("fault_walk", int'(ped_walk), 0);
        chk("fault_dw", int'(ped_dontwalk), 15);
        chk("fault_hold", int'(hold_req), 1);
        tl_red = 1'b1;
        tick(C - 1);
        chk("fault_clear_hold", int'(hold_req), 1);
        tick(1);
        chk("fault_idle", int'(hold_req), 0);
        chk("fault_keep", int'(fault), 1);
        tick(3);
        chk("fault_sticky", int'(fault), 1);

        // reset in the middle of a phase
        ped_btn = 4'b0010;
        tick(1);
        ped_btn = 4'd0;
        tick(2);
        chk("pre_grant", int'(grant_idx), 1);
`ifdef TL_PED_FLASH_EN
        tick(W + 2);
        chk("pre_flash_walk", int'(ped_walk), 0);
        chk("pre_flash_hold", int'(hold_req), 1);
`else
        tick(5);
        chk("pre_walk", int'(ped_walk), 2);
`endif
        arstN = 1'b0;
        tick(1);
        chk_all("midrst", 1'b0, 4'h0, 4'hf, 4'h0, 2'd0, 1'b0);
        arstN = 1'b1;
        tick(1);
        chk("post_rst_idle", int'(hold_req), 0);
        ped_btn = 4'b1001;
        tick(1);
        ped_btn = 4'd0;
        tick(2);
        chk("rst_rr_grant", int'(grant_idx), 0);
        chk("rst_rr_walk", int'(ped_walk), 1);
        chk("rst_rr_pend", int'(pending), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
